// File: rtl/sram_port_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_port_ctrl_pkg
// Shared types and constants for the SRAM port controller.
//   ctrl_state_e   : controller FSM state (zero-fill sweep / normal operation)
//   RSP_FIFO_DEPTH : read-response buffer depth, which is also the read
//                    outstanding limit
// -----------------------------------------------------------------------------
package sram_port_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    localparam int RSP_FIFO_DEPTH = 2;

endpackage : sram_port_ctrl_pkg

// File: rtl/sram_rsp_fifo.sv
// -----------------------------------------------------------------------------
// sram_rsp_fifo
// Small synchronous FIFO that buffers SRAM read data until the consumer takes it.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   push_i / wdata_i     : write side
//   pop_i / rdata_o      : read side; rdata_o always shows the head entry
//   full_o, empty_o      : status flags
//   count_o              : number of stored entries
// -----------------------------------------------------------------------------
module sram_rsp_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == CW'(DEPTH));
    assign count_o = count;
    assign rdata_o = mem[rd_ptr];

    // A push into a full FIFO is allowed only when the head leaves this cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the reset pointers and count
    // make every entry unreachable until it is rewritten.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

endmodule : sram_rsp_fifo

// File: rtl/sram_port_ctrl.sv
// -----------------------------------------------------------------------------
// sram_port_ctrl
// Front end for a single-port SRAM macro. After reset it optionally zero-fills
// the whole array, one word per cycle, then passes requests straight through
// to the macro and buffers read data in a 2-entry response FIFO.
// Ports:
//   clk_i, rst_ni                          : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o, req_we_i,
//   req_addr_i, req_wdata_i, req_be_i      : request channel
//   rsp_valid_o/rsp_ready_i, rsp_rdata_o   : read-response channel
//   init_done_o                            : zero-fill finished or skipped
//   sram_req_o, sram_we_o, sram_addr_o,
//   sram_wdata_o, sram_be_o, sram_rdata_i  : SRAM macro port (1-cycle read)
// -----------------------------------------------------------------------------
module sram_port_ctrl
    import sram_port_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH    = 64,
    parameter  int NUM_WORDS     = 1024,
    parameter  int INIT_ON_RESET = 1,
    localparam int AW            = $clog2(NUM_WORDS),
    localparam int BW            = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [BW-1:0]         req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  init_done_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [BW-1:0]         sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    localparam int CW = $clog2(RSP_FIFO_DEPTH + 1);
    localparam ctrl_state_e RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

    ctrl_state_e   state;
    ctrl_state_e   state_d;
    logic [AW-1:0] sweep_addr;
    logic          rd_inflight;
    logic          init_done_q;
    logic          rsp_pop;
    logic          rd_slot_free;
    logic          rd_accept;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full_unused;   // the occupancy check below already bounds pushes
    logic [CW:0]   rd_occupancy;

    assign rsp_pop     = rsp_valid_o && rsp_ready_i;
    assign rsp_valid_o = !fifo_empty;
    assign init_done_o = init_done_q;

    // Reads in flight plus buffered responses, net of the one leaving now,
    // must stay below the FIFO depth so every returning word has a slot.
    assign rd_occupancy = {1'b0, fifo_count} + (CW + 1)'(rd_inflight);
    assign rd_slot_free = rd_occupancy < ((CW + 1)'(RSP_FIFO_DEPTH) + (CW + 1)'(rsp_pop));
    assign rd_accept    = (state == ST_RUN) && req_valid_i && !req_we_i && rd_slot_free;

    // ---------------------------------------------------------------- state register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RESET_STATE;
        end else begin
            state <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        state_d = state;
        if ((state == ST_INIT) && (sweep_addr == AW'(NUM_WORDS - 1))) begin
            state_d = ST_RUN;
        end
    end

    // ---------------------------------------------------------------- outputs
    // The reset term keeps the macro idle and the request channel closed while
    // rst_ni is low, even though INIT itself drives a sweep write.
    always_comb begin
        req_ready_o  = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        case (state)
            ST_INIT: begin
                sram_req_o   = rst_ni;
                sram_we_o    = 1'b1;
                sram_addr_o  = sweep_addr;
                sram_wdata_o = '0;
                sram_be_o    = '1;
            end
            ST_RUN: begin
                req_ready_o  = rst_ni && (req_we_i || rd_slot_free);
                sram_req_o   = req_valid_i && req_ready_o;
                sram_we_o    = req_we_i;
                sram_addr_o  = req_addr_i;
                sram_wdata_o = req_wdata_i;
                sram_be_o    = req_be_i;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- datapath state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sweep_addr  <= '0;
            rd_inflight <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                sweep_addr <= sweep_addr + AW'(1);
            end
            rd_inflight <= rd_accept;
            // Sticky until reset: state never leaves RUN on its own.
            init_done_q <= (state_d == ST_RUN);
        end
    end

    // SRAM read data is valid the cycle after the request, which is exactly
    // the cycle rd_inflight is high.
    sram_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rd_inflight),
        .wdata_i (sram_rdata_i),
        .pop_i   (rsp_pop),
        .rdata_o (rsp_rdata_o),
        .full_o  (fifo_full_unused),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule : sram_port_ctrl
